// File: rtl/cam_grabber_pkg.sv
// Shared types and width helpers for the camera frame grabber.
package cam_grabber_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_VS    = 2'd1,
      WAIT_FRAME = 2'd2,
      ACTIVE     = 2'd3
   } grab_state_t;

   // Counter width able to hold 0..n inclusive (row/col saturate at n).
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   // Index width for values 0..n-1, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef struct packed {
      logic sof;
      logic eol;
   } pix_tag_t;

endpackage

// File: rtl/cam_frame_grabber_if.sv
// Pixel stream from the grabber to frame-buffer or DMA logic.
interface cam_frame_grabber_if #(
   parameter int DATA_W = 16,
   parameter int ROW_W  = 9,
   parameter int COL_W  = 10
);
   logic [DATA_W-1:0] pixelData;
   logic [ROW_W-1:0]  pixelRow;
   logic [COL_W-1:0]  pixelCol;
   logic              startOfFrame;
   logic              endOfLine;
   logic              pixelValid;
   logic              pixelReady;

   modport master (
      output pixelData, pixelRow, pixelCol, startOfFrame, endOfLine, pixelValid,
      input  pixelReady
   );

   modport slave (
      input  pixelData, pixelRow, pixelCol, startOfFrame, endOfLine, pixelValid,
      output pixelReady
   );
endinterface

// File: rtl/cam_pixel_fifo.sv
// Synchronous FIFO; a write while full is accepted only if a read frees the slot.
module cam_pixel_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cam_frame_grabber.sv
// OV7670 capture in the system clock domain: oversampled camera pins, pixel
// assembly with row/col/sof/eol tags, FIFO-buffered valid/ready output.
//
// state      | meaning
// IDLE       | capture disabled
// WAIT_VS    | enabled, discarding the partial frame until vsync asserts
// WAIT_FRAME | inside vsync, row/col cleared when it deasserts
// ACTIVE     | capturing lines; next vsync assertion closes the frame
module cam_frame_grabber
   import cam_grabber_pkg::*;
#(
   parameter int H_ACTIVE          = 640,
   parameter int V_ACTIVE          = 480,
   parameter int BYTES_PER_PIXEL   = 2,
   parameter int FIFO_DEPTH        = 8,
   parameter int SYNC_STAGES       = 2,
   parameter int VSYNC_ACTIVE_HIGH = 1
) (
   input  logic          clk,
   input  logic          resetN,
   input  logic          enable,
   input  logic          clearErrors,
   input  logic          camPclk,
   input  logic          camVsync,
   input  logic          camHref,
   input  logic [7:0]    camData,
   cam_frame_grabber_if.master pix,
   output logic [15:0]   frameCount,
   output logic          overflow,
   output logic          lineError
);
   localparam int DATA_W = 8 * BYTES_PER_PIXEL;
   localparam int ROW_CW = cnt_w(V_ACTIVE);
   localparam int COL_CW = cnt_w(H_ACTIVE);
   localparam int ROW_W  = idx_w(V_ACTIVE);
   localparam int COL_W  = idx_w(H_ACTIVE);
   localparam int BC_W   = idx_w(BYTES_PER_PIXEL);
   localparam int SW     = 11;

   localparam logic [ROW_CW-1:0] ROW_MAX  = ROW_CW'(V_ACTIVE);
   localparam logic [COL_CW-1:0] COL_MAX  = COL_CW'(H_ACTIVE);
   localparam logic [COL_CW-1:0] COL_LAST = COL_CW'(H_ACTIVE - 1);
   localparam logic [BC_W-1:0]   BC_LAST  = BC_W'(BYTES_PER_PIXEL - 1);

   typedef struct packed {
      pix_tag_t          tag;
      logic [ROW_W-1:0]  row;
      logic [COL_W-1:0]  col;
      logic [DATA_W-1:0] data;
   } pix_entry_t;

   logic [SW-1:0] sync_q [SYNC_STAGES];
   logic          s_pclk, s_vsync, s_href;
   logic [7:0]    s_data;
   logic          pclk_d, vs_act_d, href_d;
   logic          vs_act, pclk_rise, vs_rise, vs_fall, href_fall;

   grab_state_t       state_q;
   logic [ROW_CW-1:0] row_q;
   logic [COL_CW-1:0] col_q;
   logic [BC_W-1:0]   byte_cnt_q;
   logic [DATA_W-1:0] shreg_q;
   logic [15:0]       frame_cnt_q;
   logic              push_q;
   pix_entry_t        entry_q;

   logic              take_byte, pix_done, col_ok, line_end, lerr_set, ovf_set;
   logic [DATA_W-1:0] pix_next;
   logic              overflow_q, line_err_q;
   logic              fifo_full, fifo_empty, pop;
   pix_entry_t        head;

   // All camera pins share one pipeline so data stays aligned with pclk.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         pclk_d   <= 1'b0;
         vs_act_d <= 1'b0;
         href_d   <= 1'b0;
      end else begin
         sync_q[0] <= {camPclk, camVsync, camHref, camData};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         pclk_d   <= s_pclk;
         vs_act_d <= vs_act;
         href_d   <= s_href;
      end
   end

   assign {s_pclk, s_vsync, s_href, s_data} = sync_q[SYNC_STAGES-1];
   assign vs_act    = (VSYNC_ACTIVE_HIGH != 0) ? s_vsync : ~s_vsync;
   assign pclk_rise = s_pclk & ~pclk_d;
   assign vs_rise   = vs_act & ~vs_act_d;
   assign vs_fall   = ~vs_act & vs_act_d;
   assign href_fall = ~s_href & href_d;

   // Lines past V_ACTIVE are ignored entirely, including the length check.
   always_comb begin
      take_byte = (state_q == ACTIVE) && pclk_rise && s_href && (row_q < ROW_MAX);
      pix_done  = take_byte && (byte_cnt_q == BC_LAST);
      col_ok    = (col_q < COL_MAX);
      line_end  = (state_q == ACTIVE) && href_fall && (row_q < ROW_MAX);
      lerr_set  = (pix_done && !col_ok) || (line_end && (col_q != COL_MAX));
      pix_next  = (shreg_q << 8) | DATA_W'(s_data);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= IDLE;
         row_q       <= '0;
         col_q       <= '0;
         byte_cnt_q  <= '0;
         shreg_q     <= '0;
         frame_cnt_q <= '0;
         push_q      <= 1'b0;
         entry_q     <= '0;
      end else begin
         push_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (enable) state_q <= WAIT_VS;
            end
            WAIT_VS: begin
               if (vs_rise) state_q <= enable ? WAIT_FRAME : IDLE;
            end
            WAIT_FRAME: begin
               if (vs_fall) begin
                  state_q    <= ACTIVE;
                  row_q      <= '0;
                  col_q      <= '0;
                  byte_cnt_q <= '0;
               end
            end
            ACTIVE: begin
               if (vs_rise) begin
                  frame_cnt_q <= frame_cnt_q + 16'd1;
                  state_q     <= enable ? WAIT_FRAME : IDLE;
               end else if (line_end) begin
                  row_q      <= row_q + ROW_CW'(1);
                  col_q      <= '0;
                  byte_cnt_q <= '0;
               end else if (href_fall) begin
                  byte_cnt_q <= '0;
               end else if (take_byte) begin
                  shreg_q <= pix_next;
                  if (pix_done) begin
                     byte_cnt_q <= '0;
                     if (col_ok) begin
                        push_q           <= 1'b1;
                        entry_q.tag.sof  <= (row_q == '0) && (col_q == '0);
                        entry_q.tag.eol  <= (col_q == COL_LAST);
                        entry_q.row      <= row_q[ROW_W-1:0];
                        entry_q.col      <= col_q[COL_W-1:0];
                        entry_q.data     <= pix_next;
                        col_q            <= col_q + COL_CW'(1);
                     end
                  end else begin
                     byte_cnt_q <= byte_cnt_q + BC_W'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   cam_pixel_fifo #(
      .WIDTH ($bits(pix_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetN  (resetN),
      .wr_en   (push_q),
      .wr_data (entry_q),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign pop     = pix.pixelValid & pix.pixelReady;
   assign ovf_set = push_q & fifo_full & ~pop;

   // Set has priority over a coincident clear.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         overflow_q <= 1'b0;
         line_err_q <= 1'b0;
      end else begin
         overflow_q <= ovf_set  | (overflow_q & ~clearErrors);
         line_err_q <= lerr_set | (line_err_q & ~clearErrors);
      end
   end

   assign pix.pixelValid   = ~fifo_empty;
   assign pix.pixelData    = fifo_empty ? '0   : head.data;
   assign pix.pixelRow     = fifo_empty ? '0   : head.row;
   assign pix.pixelCol     = fifo_empty ? '0   : head.col;
   assign pix.startOfFrame = fifo_empty ? 1'b0 : head.tag.sof;
   assign pix.endOfLine    = fifo_empty ? 1'b0 : head.tag.eol;
   assign frameCount       = frame_cnt_q;
   assign overflow         = overflow_q;
   assign lineError        = line_err_q;

endmodule

// File: tb/tb_cam_frame_grabber.sv
// Scoreboard bench: the camera driver queues expected pixels, a monitor pops them.
module tb_cam_frame_grabber;
   localparam int H     = 4;
   localparam int V     = 3;
   localparam int BPP   = 2;
   localparam int DEPTH = 8;
   localparam int SYNC  = 2;
   localparam int LAT   = (SYNC + 2) * 10 + 4;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        enable = 1'b0;
   logic        clearErrors = 1'b0;
   logic        camPclk = 1'b0;
   logic        camVsync = 1'b0;
   logic        camHref = 1'b0;
   logic [7:0]  camData = 8'h00;
   logic [15:0] frameCount;
   logic        overflow;
   logic        lineError;

   cam_frame_grabber_if #(.DATA_W(16), .ROW_W(2), .COL_W(2)) pix ();

   cam_frame_grabber #(
      .H_ACTIVE(H), .V_ACTIVE(V), .BYTES_PER_PIXEL(BPP), .FIFO_DEPTH(DEPTH),
      .SYNC_STAGES(SYNC), .VSYNC_ACTIVE_HIGH(1)
   ) dut (
      .clk(clk), .resetN(resetN), .enable(enable), .clearErrors(clearErrors),
      .camPclk(camPclk), .camVsync(camVsync), .camHref(camHref), .camData(camData),
      .pix(pix), .frameCount(frameCount), .overflow(overflow), .lineError(lineError)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      int          row;
      int          col;
      logic        sof;
      logic        eol;
      bit          chk_lat;
      time         t;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   room  = 1000;
   int   kbyte = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [7:0] bval(input int k);
      logic [7:0] v;
      v = 8'h12 + 8'(34 * k);
      return v;
   endfunction

   always @(negedge clk) begin
      if (resetN && pix.pixelValid && pix.pixelReady) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pixel got data=%h row=%0d col=%0d want none",
                     pix.pixelData, pix.pixelRow, pix.pixelCol);
         end else begin
            mon_e = sb.pop_front();
            if (pix.pixelData !== mon_e.data || int'(pix.pixelRow) != mon_e.row ||
                int'(pix.pixelCol) != mon_e.col || pix.startOfFrame !== mon_e.sof ||
                pix.endOfLine !== mon_e.eol) begin
               bad++;
               $display("FAIL pixel got d=%h r=%0d c=%0d sof=%b eol=%b want d=%h r=%0d c=%0d sof=%b eol=%b",
                        pix.pixelData, pix.pixelRow, pix.pixelCol, pix.startOfFrame, pix.endOfLine,
                        mon_e.data, mon_e.row, mon_e.col, mon_e.sof, mon_e.eol);
            end
            if (mon_e.chk_lat) begin
               total++;
               if (($time - mon_e.t) != LAT) begin
                  bad++;
                  $display("FAIL latency got=%0t want=%0d", $time - mon_e.t, LAT);
               end
            end
         end
      end
   end

   // One pixel = BPP bytes, pclk = clk/4; expectation queued at the completing edge.
   task automatic send_pix(input int row, input int c, input bit en, input bit lat);
      logic [7:0] b0, b1;
      exp_t       e;
      b0 = bval(kbyte);
      b1 = bval(kbyte + 1);
      kbyte += 2;
      camData = b0; camPclk = 1'b0; tick(2); camPclk = 1'b1; tick(2);
      camData = b1; camPclk = 1'b0; tick(2); camPclk = 1'b1;
      if (en && c < H && row < V && room > 0) begin
         room--;
         e.data = {b0, b1}; e.row = row; e.col = c;
         e.sof = (row == 0 && c == 0); e.eol = (c == H - 1);
         e.chk_lat = lat; e.t = $time;
         sb.push_back(e);
      end
      tick(2);
   endtask

   task automatic send_line(input int row, input int npix, input bit en, input bit lat);
      camHref = 1'b1;
      for (int c = 0; c < npix; c++) send_pix(row, c, en, lat);
      camPclk = 1'b0; camHref = 1'b0;
      tick(8);
   endtask

   task automatic send_frame(input int n0, input int n1, input int n2, input bit en, input bit lat);
      kbyte = 0;
      send_line(0, n0, en, lat);
      send_line(1, n1, en, lat);
      send_line(2, n2, en, lat);
   endtask

   task automatic vsync_pulse();
      camVsync = 1'b1; tick(8);
      camVsync = 1'b0; tick(8);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
      check(name, sb.size(), 0);
   endtask

   task automatic pulse_clear();
      clearErrors = 1'b1; tick(1);
      clearErrors = 1'b0; tick(1);
   endtask

   initial begin
      pix.pixelReady = 1'b1;
      tick(3);
      check("reset_valid", pix.pixelValid, 0);
      check("reset_outputs", {pix.pixelData, pix.pixelRow, pix.pixelCol, pix.startOfFrame, pix.endOfLine}, 0);
      check("reset_flags", {frameCount, overflow, lineError}, 0);
      resetN = 1'b1;
      tick(2);
      enable = 1'b1;
      tick(2);

      // Frame A: full 4x3 frame, first pixel 0x1234, latency checked.
      vsync_pulse();
      send_frame(4, 4, 4, 1, 1);
      wait_drain("frameA_drain");
      check("frameA_count_before_vs", frameCount, 0);
      vsync_pulse();
      check("frameA_count", frameCount, 1);
      check("frameA_flags", {overflow, lineError}, 0);

      // Frame B: short line then long line; 5th pixel dropped, next line at col 0.
      send_frame(3, 5, 4, 1, 1);
      check("frameB_lineError", lineError, 1);
      wait_drain("frameB_drain");
      vsync_pulse();
      check("frameB_count", frameCount, 2);
      pulse_clear();
      check("frameB_lineError_cleared", lineError, 0);

      // Frame C: ready low, FIFO keeps 8, overflow set, head stable.
      pix.pixelReady = 1'b0;
      room = DEPTH;
      send_frame(4, 4, 4, 1, 0);
      check("frameC_valid", pix.pixelValid, 1);
      check("frameC_head", {pix.startOfFrame, pix.pixelData}, {1'b1, 16'h1234});
      tick(10);
      check("frameC_head_stable", {pix.startOfFrame, pix.pixelData}, {1'b1, 16'h1234});
      check("frameC_overflow", overflow, 1);
      pulse_clear();
      check("frameC_overflow_cleared", overflow, 0);
      vsync_pulse();
      check("frameC_count", frameCount, 3);
      room = 1000;
      pix.pixelReady = 1'b1;
      wait_drain("frameC_drain");

      // Frame D: enable dropped mid-frame, frame still completes.
      kbyte = 0;
      send_line(0, 4, 1, 1);
      enable = 1'b0;
      send_line(1, 4, 1, 1);
      send_line(2, 4, 1, 1);
      wait_drain("frameD_drain");
      vsync_pulse();
      check("frameD_count", frameCount, 4);

      // Frame E: idle, enable raised mid-frame; nothing until a full vsync.
      kbyte = 0;
      send_line(0, 4, 0, 0);
      enable = 1'b1;
      send_line(1, 4, 0, 0);
      send_line(2, 4, 0, 0);
      vsync_pulse();
      check("frameE_not_counted", frameCount, 4);
      send_frame(4, 4, 4, 1, 1);
      wait_drain("frameG_drain");
      vsync_pulse();
      check("frameG_count", frameCount, 5);

      // Reset mid-line with pixels buffered.
      pix.pixelReady = 1'b0;
      kbyte = 0;
      camHref = 1'b1;
      send_pix(0, 0, 1, 0);
      send_pix(0, 1, 1, 0);
      tick(4);
      check("pre_reset_valid", pix.pixelValid, 1);
      resetN = 1'b0;
      #1;
      check("midreset_valid", pix.pixelValid, 0);
      check("midreset_counters", {frameCount, overflow, lineError, pix.pixelRow, pix.pixelCol}, 0);
      sb.delete();
      tick(3);
      resetN = 1'b1;
      pix.pixelReady = 1'b1;
      send_pix(0, 2, 0, 0);
      send_pix(0, 3, 0, 0);
      camPclk = 1'b0; camHref = 1'b0;
      tick(8);
      send_line(1, 4, 0, 0);
      send_line(2, 4, 0, 0);
      tick(10);
      check("post_reset_count", frameCount, 0);
      vsync_pulse();
      send_frame(4, 4, 4, 1, 1);
      wait_drain("post_reset_drain");
      vsync_pulse();
      check("post_reset_frame_count", frameCount, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
